gemm_stream_host: RTL and testbench

Host-side driver for the GEMM core. Accepts a job as a serial valid/ready element stream (alpha, beta, A, B, C), assembles the parallel matrix operands, primes and starts the core, waits for completion, and returns the result matrix as a valid/ready output stream. It sits between the system streaming fabric and the GEMM core's parallel-array ports.

---
 rtl/gemm_pkg.sv | 31 +++
 rtl/gemm_result_serializer.sv | 66 ++++++
 rtl/gemm_stream_host.sv | 143 ++++++++++++++
 tb/tb_gemm_stream_host.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gemm_pkg
// Description : Shared types and sizing helpers for the GEMM stream host.
// Revision    : 1.0 - initial release
// ============================================================================
package gemm_pkg;

  // Job sequencing states of the host
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_PRIME   = 3'd2,
    ST_START   = 3'd3,
    ST_WAIT    = 3'd4,
    ST_CAPTURE = 3'd5,
    ST_DRAIN   = 3'd6
  } state_t;

  // Input beats per job: alpha, beta, then A, B and C
  function automatic int nbeats(input int h, input int w);
    return 2 + 3 * h * w;
  endfunction

  // Result beats per job
  function automatic int nresult(input int h, input int w);
    return h * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gemm_result_serializer.sv
`default_nettype none
// ============================================================================
// Module      : gemm_result_serializer
// Description : Holds the captured result matrix and streams it out
//               row-major over a registered valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module gemm_result_serializer #(
  parameter int DATA_WIDTH    = 64,
  parameter int MATRIX_WIDTH  = 4,
  parameter int MATRIX_HEIGHT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] result_matrix [MATRIX_HEIGHT][MATRIX_WIDTH],
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last,
  output logic                  done
);

  localparam int NRES = MATRIX_HEIGHT * MATRIX_WIDTH;
  localparam int IW   = (NRES > 1) ? $clog2(NRES) : 1;

  logic [DATA_WIDTH-1:0] buffer [NRES];
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_next;
  logic                  fire;

  assign fire     = valid && ready;
  assign done     = fire && last;
  assign idx_next = idx + 1'b1;

  // Buffer load on capture, then advance one beat per handshake.
  // The beat presented is always registered, so it holds while ready is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NRES; i++) buffer[i] <= '0;
      idx   <= '0;
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      for (int r = 0; r < MATRIX_HEIGHT; r++)
        for (int c = 0; c < MATRIX_WIDTH; c++)
          buffer[r*MATRIX_WIDTH + c] <= result_matrix[r][c];
      idx   <= '0;
      valid <= 1'b1;
      data  <= result_matrix[0][0];
      last  <= 1'(NRES == 1);
    end else if (fire) begin
      if (last) begin
        valid <= 1'b0;
        last  <= 1'b0;
      end else begin
        idx  <= idx_next;
        data <= buffer[idx_next];
        last <= (idx_next == IW'(NRES - 1));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gemm_stream_host.sv
`default_nettype none
// ============================================================================
// Module      : gemm_stream_host
// Description : Streams a GEMM job (alpha, beta, A, B, C) in, drives the core's
//               parallel operand ports, sequences reset/start/done, and
//               streams the result matrix back out.
// Revision    : 1.0 - initial release
// ============================================================================
module gemm_stream_host
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int MATRIX_WIDTH  = 4,
  parameter int MATRIX_HEIGHT = 4
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  is_valid,
  input  logic [DATA_WIDTH-1:0] is_data,
  output logic                  is_ready,
  output logic [DATA_WIDTH-1:0] oalpha,
  output logic [DATA_WIDTH-1:0] obeta,
  output logic [DATA_WIDTH-1:0] oa_matrix [MATRIX_HEIGHT][MATRIX_WIDTH],
  output logic [DATA_WIDTH-1:0] ob_matrix [MATRIX_HEIGHT][MATRIX_WIDTH],
  output logic [DATA_WIDTH-1:0] oc_matrix [MATRIX_HEIGHT][MATRIX_WIDTH],
  output logic                  ogemm_rst,
  output logic                  ostart,
  input  logic                  igemm_busy,
  input  logic                  igemm_done,
  input  logic [DATA_WIDTH-1:0] iresult_matrix [MATRIX_HEIGHT][MATRIX_WIDTH],
  output logic                  om_valid,
  output logic [DATA_WIDTH-1:0] om_data,
  output logic                  om_last,
  input  logic                  im_ready,
  output logic                  obusy
);

  localparam int NBEATS = nbeats(MATRIX_HEIGHT, MATRIX_WIDTH);
  localparam int ELEMS  = nresult(MATRIX_HEIGHT, MATRIX_WIDTH);
  localparam int CW     = $clog2(NBEATS + 1);

  state_t        state, state_next;
  logic [CW-1:0] count;
  logic [CW-1:0] beat_idx;
  logic          in_fire;
  logic          prime;
  logic          start;
  logic          capture;
  logic          drain_done;
  logic          busy_unused;

  // Core busy is informational only; sequencing relies on the done strobe
  assign busy_unused = igemm_busy;

  assign is_ready  = (state == ST_IDLE) || (state == ST_LOAD);
  assign in_fire   = is_valid && is_ready;
  // The first beat of a job is always alpha, whatever count was left at
  assign beat_idx  = (state == ST_IDLE) ? '0 : count;
  // System reset must also reach the core; the prime pulse alone does not
  assign ogemm_rst = prime | irst;
  assign ostart    = start;
  assign obusy     = (state != ST_IDLE);

  // State register
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state decode and single-cycle core strobes
  always_comb begin
    state_next = state;
    prime      = 1'b0;
    start      = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE:    if (in_fire) state_next = ST_LOAD;
      ST_LOAD:    if (in_fire && (count == CW'(NBEATS - 1))) state_next = ST_PRIME;
      ST_PRIME: begin
        prime      = 1'b1;
        state_next = ST_START;
      end
      ST_START: begin
        start      = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT:    if (igemm_done) state_next = ST_CAPTURE;
      ST_CAPTURE: begin
        capture    = 1'b1;
        state_next = ST_DRAIN;
      end
      ST_DRAIN:   if (drain_done) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Input beat counter: index of the next beat to be written
  always_ff @(posedge iclk or posedge irst) begin
    if (irst)         count <= '0;
    else if (in_fire) count <= beat_idx + 1'b1;
  end

  // Operand registers: route each accepted beat to its scalar/matrix slot
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      oalpha <= '0;
      obeta  <= '0;
      for (int r = 0; r < MATRIX_HEIGHT; r++)
        for (int c = 0; c < MATRIX_WIDTH; c++) begin
          oa_matrix[r][c] <= '0;
          ob_matrix[r][c] <= '0;
          oc_matrix[r][c] <= '0;
        end
    end else if (in_fire) begin
      if (beat_idx == CW'(0)) oalpha <= is_data;
      if (beat_idx == CW'(1)) obeta  <= is_data;
      for (int r = 0; r < MATRIX_HEIGHT; r++)
        for (int c = 0; c < MATRIX_WIDTH; c++) begin
          if (beat_idx == CW'(2 + r*MATRIX_WIDTH + c))             oa_matrix[r][c] <= is_data;
          if (beat_idx == CW'(2 + ELEMS + r*MATRIX_WIDTH + c))     ob_matrix[r][c] <= is_data;
          if (beat_idx == CW'(2 + 2*ELEMS + r*MATRIX_WIDTH + c))   oc_matrix[r][c] <= is_data;
        end
    end
  end

  gemm_result_serializer #(
    .DATA_WIDTH    (DATA_WIDTH),
    .MATRIX_WIDTH  (MATRIX_WIDTH),
    .MATRIX_HEIGHT (MATRIX_HEIGHT)
  ) u_serializer (
    .clk           (iclk),
    .rst           (irst),
    .load          (capture),
    .result_matrix (iresult_matrix),
    .ready         (im_ready),
    .valid         (om_valid),
    .data          (om_data),
    .last          (om_last),
    .done          (drain_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_gemm_stream_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_gemm_stream_host
// Description : Self-checking bench for gemm_stream_host with a latency-20
//               GEMM core model and a reference result computed per job.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gemm_stream_host;

  localparam int DW  = 64;
  localparam int H   = 4;
  localparam int W   = 4;
  localparam int N   = H * W;
  localparam int NB  = 2 + 3 * N;
  localparam int LAT = 20;

  logic          iclk = 1'b0;
  logic          irst;
  logic          is_valid;
  logic [DW-1:0] is_data;
  logic          is_ready;
  logic [DW-1:0] oalpha, obeta;
  logic [DW-1:0] oa_matrix [H][W];
  logic [DW-1:0] ob_matrix [H][W];
  logic [DW-1:0] oc_matrix [H][W];
  logic          ogemm_rst, ostart;
  logic          igemm_busy, igemm_done;
  logic [DW-1:0] iresult_matrix [H][W];
  logic          om_valid;
  logic [DW-1:0] om_data;
  logic          om_last;
  logic          im_ready;
  logic          obusy;

  logic          core_done = 1'b0;
  logic          spur_done;
  int            core_cnt = 0;
  logic [DW-1:0] c_lat [H][W];
  logic [DW-1:0] core_acc;

  int n_err = 0, n_chk = 0;
  int cyc = 0, done_cyc = -100;
  int n_prime = 0, n_start = 0;

  // Job reference data
  logic [DW-1:0] ja, jb;
  logic [DW-1:0] ma [H][W];
  logic [DW-1:0] mb [H][W];
  logic [DW-1:0] mc [H][W];
  logic [DW-1:0] stim [$];
  logic [DW-1:0] expv [N];

  assign igemm_done = core_done | spur_done;
  assign igemm_busy = (core_cnt != 0);

  gemm_stream_host #(
    .DATA_WIDTH(DW), .MATRIX_WIDTH(W), .MATRIX_HEIGHT(H)
  ) dut (
    .iclk(iclk), .irst(irst), .is_valid(is_valid), .is_data(is_data), .is_ready(is_ready),
    .oalpha(oalpha), .obeta(obeta), .oa_matrix(oa_matrix), .ob_matrix(ob_matrix),
    .oc_matrix(oc_matrix), .ogemm_rst(ogemm_rst), .ostart(ostart), .igemm_busy(igemm_busy),
    .igemm_done(igemm_done), .iresult_matrix(iresult_matrix), .om_valid(om_valid),
    .om_data(om_data), .om_last(om_last), .im_ready(im_ready), .obusy(obusy)
  );

  always #5 iclk = ~iclk;

  always @(posedge iclk) cyc++;

  // GEMM core model: latches C on its reset, done LAT cycles after start,
  // result updated on the edge that ends the done cycle
  always @(posedge iclk or posedge irst) begin
    if (irst) begin
      core_cnt  <= 0;
      core_done <= 1'b0;
    end else begin
      if (ogemm_rst)
        for (int r = 0; r < H; r++)
          for (int c = 0; c < W; c++) c_lat[r][c] <= oc_matrix[r][c];
      if (ostart) core_cnt <= LAT;
      else if (core_cnt != 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1) core_done <= 1'b1;
      end
      if (core_done) begin
        core_done <= 1'b0;
        for (int r = 0; r < H; r++)
          for (int c = 0; c < W; c++) begin
            core_acc = '0;
            for (int k = 0; k < W; k++) core_acc = core_acc + oa_matrix[r][k] * ob_matrix[k][c];
            iresult_matrix[r][c] <= oalpha * core_acc + obeta * c_lat[r][c];
          end
      end
    end
  end

  // Pulse and done-time monitor
  always @(negedge iclk) begin
    if (core_done) done_cyc = cyc;
    if (!irst && ogemm_rst) n_prime++;
    if (ostart) n_start++;
  end

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // kind 0: alpha=1 beta=0 A=I B=1..16 C=0; kind 1: alpha=2 beta=3 all ones; else random
  task automatic fill(input int kind);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        case (kind)
          0: begin ma[r][c] = (r == c) ? 1 : 0; mb[r][c] = DW'(r*W + c + 1); mc[r][c] = 0; end
          1: begin ma[r][c] = 1; mb[r][c] = 1; mc[r][c] = 1; end
          default: begin
            ma[r][c] = {$urandom, $urandom};
            mb[r][c] = {$urandom, $urandom};
            mc[r][c] = {$urandom, $urandom};
          end
        endcase
      end
    case (kind)
      0: begin ja = 1; jb = 0; end
      1: begin ja = 2; jb = 3; end
      default: begin ja = {$urandom, $urandom}; jb = {$urandom, $urandom}; end
    endcase
  endtask

  // Build the input beat stream and the expected result beats
  task automatic build_ref();
    logic [DW-1:0] acc;
    stim.delete();
    stim.push_back(ja);
    stim.push_back(jb);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) stim.push_back(ma[r][c]);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) stim.push_back(mb[r][c]);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) stim.push_back(mc[r][c]);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        acc = '0;
        for (int k = 0; k < W; k++) acc += ma[r][k] * mb[k][c];
        expv[r*W + c] = ja * acc + jb * mc[r][c];
      end
  endtask

  // gap_mode: 0 none, 1 every other cycle, 2 random; ready_mode: 0 high, 1 random, 2 stall at beat 7
  task automatic run_job(input int gap_mode, input int ready_mode, input bit spur, input int rst_at);
    int  t, k, stall, g;
    bit  spur_d;
    build_ref();
    n_prime = 0;
    n_start = 0;
    for (int i = 0; i < NB; i++) begin
      g = (gap_mode == 1) ? int'(i > 0) : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin is_valid = 1'b0; @(negedge iclk); end
      is_valid  = 1'b1;
      is_data   = stim[i];
      spur_done = spur && (i == 20);
      t = 0;
      #1;
      while (!is_ready && t < 20) begin @(negedge iclk); spur_done = 1'b0; t++; #1; end
      if (!is_ready) begin
        check_eq("in_accept_timeout", 0, 1);
        is_valid = 1'b0;
        return;
      end
      @(negedge iclk);
      spur_done = 1'b0;
    end
    // Keep offering beats: nothing more may be accepted
    is_data = 64'hDEAD_BEEF;
    #1;
    check_eq("prime_is_ready", DW'(is_ready), 0);
    check_eq("prime_gemm_rst", DW'(ogemm_rst), 1);
    check_eq("prime_start", DW'(ostart), 0);
    check_eq("prime_busy", DW'(obusy), 1);
    @(negedge iclk); #1;
    check_eq("start_pulse", DW'(ostart), 1);
    check_eq("start_gemm_rst", DW'(ogemm_rst), 0);
    check_eq("start_is_ready", DW'(is_ready), 0);
    is_valid = 1'b0;
    t = 0;
    while (!om_valid && t < 200) begin @(negedge iclk); #1; t++; end
    if (!om_valid) begin
      check_eq("out_valid_timeout", 0, 1);
      return;
    end
    check_eq("first_beat_latency", DW'(cyc), DW'(done_cyc + 2));
    check_eq("prime_pulses", DW'(n_prime), 1);
    check_eq("start_pulses", DW'(n_start), 1);
    k = 0; t = 0; stall = 0; spur_d = 1'b0;
    while (k < N && t < 400) begin
      im_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ready_mode == 2 && k == 7 && stall < 5) begin im_ready = 1'b0; stall++; end
      if (spur && k == 4 && !spur_d) begin spur_done = 1'b1; spur_d = 1'b1; end
      #1;
      check_eq("drain_valid", DW'(om_valid), 1);
      check_eq("drain_busy", DW'(obusy), 1);
      check_eq("drain_is_ready", DW'(is_ready), 0);
      if (om_valid) begin
        check_eq($sformatf("beat%0d_data", k), om_data, expv[k]);
        check_eq($sformatf("beat%0d_last", k), DW'(om_last), DW'(k == N - 1));
        if (k == rst_at) begin
          #1 irst = 1'b1;
          #1;
          check_eq("async_rst_valid", DW'(om_valid), 0);
          check_eq("async_rst_busy", DW'(obusy), 0);
          check_eq("async_rst_is_ready", DW'(is_ready), 1);
          spur_done = 1'b0;
          @(negedge iclk);
          irst = 1'b0;
          im_ready = 1'b1;
          repeat (5) begin
            @(negedge iclk); #1;
            check_eq("post_rst_no_beat", DW'(om_valid), 0);
          end
          return;
        end
        if (im_ready) k++;
      end
      @(negedge iclk);
      spur_done = 1'b0;
      t++;
    end
    check_eq("beats_delivered", DW'(k), DW'(N));
    im_ready = 1'b0;
    #1;
    check_eq("end_valid", DW'(om_valid), 0);
    check_eq("end_busy", DW'(obusy), 0);
    check_eq("end_is_ready", DW'(is_ready), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    irst      = 1'b1;
    is_valid  = 1'b0;
    is_data   = '0;
    im_ready  = 1'b0;
    spur_done = 1'b0;
    repeat (2) @(negedge iclk);
    #1;
    check_eq("rst_is_ready", DW'(is_ready), 1);
    check_eq("rst_om_valid", DW'(om_valid), 0);
    check_eq("rst_om_data", om_data, 0);
    check_eq("rst_om_last", DW'(om_last), 0);
    check_eq("rst_obusy", DW'(obusy), 0);
    check_eq("rst_ostart", DW'(ostart), 0);
    check_eq("rst_alpha", oalpha, 0);
    check_eq("rst_a00", oa_matrix[0][0], 0);
    @(negedge iclk);
    irst = 1'b0;
    #1;
    check_eq("rst_gemm_rst_released", DW'(ogemm_rst), 0);

    @(negedge iclk); fill(0); run_job(0, 0, 1'b0, -1);   // identity: beats 1..16
    @(negedge iclk); fill(1); run_job(0, 0, 1'b0, -1);   // all ones: beats of 11
    @(negedge iclk); fill(0); run_job(1, 0, 1'b0, -1);   // input every other cycle
    @(negedge iclk); fill(2); run_job(2, 2, 1'b0, -1);   // downstream stall at beat 7
    @(negedge iclk); fill(2); run_job(0, 1, 1'b1, -1);   // spurious done, random ready
    @(negedge iclk); fill(2); run_job(0, 0, 1'b1, -1);   // back-to-back job
    @(negedge iclk); fill(2); run_job(2, 0, 1'b0, 8);    // async reset mid-drain
    @(negedge iclk); fill(2); run_job(2, 1, 1'b0, -1);   // full job after reset

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
